// File: rtl/clkdiv_prog.sv
// Multi-channel programmable clock divider: N_CH divided clocks with per-channel
// divisor, enable and tick strobe, plus a common sync restart.

module clkdiv_ch #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 48000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wdata,
    output logic             clk_div,
    output logic             tick
);
    localparam logic [DIV_W-1:0] DEF   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W:0]   ONE_X = (DIV_W+1)'(1);

    logic [DIV_W-1:0] cnt, d_act, d_pend;
    logic             run;
    logic [DIV_W:0]   half, nxt;
    logic             start, hi_nxt;

    // One bit of headroom keeps cnt+1 exact at the largest divisor.
    assign half   = {1'b0, d_act} - {2'b0, d_act[DIV_W-1:1]};
    assign nxt    = {1'b0, cnt} + ONE_X;
    assign hi_nxt = nxt < half;
    assign start  = en && (!run || sync || (cnt == d_act - ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_pend <= DEF;
        end else if (wr) begin
            d_pend <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            d_act   <= DEF;
            run     <= 1'b0;
            clk_div <= 1'b0;
            tick    <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            run     <= 1'b0;
            clk_div <= 1'b0;
            tick    <= 1'b0;
        end else if (start) begin
            // d_pend here is the pre-edge value, so a same-edge write waits a period.
            cnt     <= '0;
            d_act   <= d_pend;
            run     <= 1'b1;
            clk_div <= 1'b1;
            tick    <= 1'b1;
        end else begin
            cnt     <= cnt + ONE;
            clk_div <= hi_nxt;
            tick    <= 1'b0;
        end
    end
endmodule

module clkdiv_prog #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 48000,
    parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [N_CH-1:0]   clk_div,
    output logic [N_CH-1:0]   tick
);
    localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

    logic            cfg_ok;
    logic [N_CH-1:0] wr;

    assign cfg_ok = (32'(cfg_ch) < N_CH) && (cfg_div >= TWO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_err <= 1'b0;
        else        cfg_err <= cfg_we && !cfg_ok;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr[i] = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));

        clkdiv_ch #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en[i]),
            .sync   (sync),
            .wr     (wr[i]),
            .wdata  (cfg_div),
            .clk_div(clk_div[i]),
            .tick   (tick[i])
        );
    end
endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed bench for clkdiv_prog: default period, divisor programming, sync,
// enable and reset behaviour, plus rejected writes on a 3-channel instance.

module tb_clkdiv_prog;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  en = '0;
    logic        sync = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_div = '0;
    logic        cfg_err;
    logic [3:0]  clk_div, tick;

    logic [2:0]  en_b = '0;
    logic        cfg_we_b = 1'b0;
    logic [1:0]  cfg_ch_b = '0;
    logic [7:0]  cfg_div_b = '0;
    logic        cfg_err_b;
    logic [2:0]  clk_div_b, tick_b;

    int n_chk = 0;
    int n_fail = 0;

    clkdiv_prog u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_err(cfg_err),
        .clk_div(clk_div), .tick(tick)
    );

    clkdiv_prog #(.N_CH(3), .DIV_W(8), .DEFAULT_DIV(10)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .sync(1'b0), .cfg_we(cfg_we_b),
        .cfg_ch(cfg_ch_b), .cfg_div(cfg_div_b), .cfg_err(cfg_err_b),
        .clk_div(clk_div_b), .tick(tick_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cfg(input logic [1:0] ch, input logic [15:0] d);
        cfg_we = 1'b1; cfg_ch = ch; cfg_div = d;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        int hi, tk, hi1;
        logic [3:0] other;
        logic [9:0] v0, t0, v1, t1;

        // reset state
        step(); step();
        check("rst_clk_div", 32'(clk_div), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_cfg_err", 32'(cfg_err), 32'h0);
        check("rst_b_out", 32'({clk_div_b, tick_b}), 32'h0);

        // default divisor on ch0: one full 48000-cycle period
        rst_n = 1'b1; en = 4'b0001;
        step();
        hi = 0; tk = 0; other = '0;
        for (int i = 0; i < 48000; i++) begin
            if (i == 0)     check("def_first", 32'({clk_div[0], tick[0]}), 32'b11);
            if (i == 23999) check("def_last_hi", 32'(clk_div[0]), 32'h1);
            if (i == 24000) check("def_first_lo", 32'(clk_div[0]), 32'h0);
            hi += int'(clk_div[0]);
            tk += int'(tick[0]);
            other |= {clk_div[3:1], 1'b0} | {tick[3:1], 1'b0};
            step();
        end
        check("def_hi_cnt", 32'(hi), 32'd24000);
        check("def_tick_cnt", 32'(tk), 32'd1);
        check("def_others_idle", 32'(other), 32'h0);
        check("def_next_start", 32'({clk_div[0], tick[0]}), 32'b11);

        // ch1 at D=5
        en = 4'b0000;
        step();
        wr_cfg(2'd1, 16'd5);
        check("d5_no_err", 32'(cfg_err), 32'h0);
        en = 4'b0010;
        step();
        for (int i = 0; i < 10; i++) begin
            v1 = {v1[8:0], clk_div[1]};
            t1 = {t1[8:0], tick[1]};
            step();
        end
        check("d5_clk", 32'(v1), 32'b1110011100);
        check("d5_tick", 32'(t1), 32'b1000010000);

        // ch0 D=4, rewritten to 3 mid-period
        wr_cfg(2'd0, 16'd4);
        en = 4'b0011;
        step();
        for (int i = 0; i < 10; i++) begin
            v0 = {v0[8:0], clk_div[0]};
            t0 = {t0[8:0], tick[0]};
            if (i == 1) begin
                cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3;
            end else begin
                cfg_we = 1'b0;
            end
            step();
        end
        check("d4to3_clk", 32'(v0), 32'b1100110110);
        check("d4to3_tick", 32'(t0), 32'b1000100100);

        // rejected writes
        wr_cfg(2'd2, 16'd1);
        check("err_div1", 32'(cfg_err), 32'h1);
        wr_cfg(2'd0, 16'd0);
        check("err_div0", 32'(cfg_err), 32'h1);
        step();
        check("err_clear", 32'(cfg_err), 32'h0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int i = 0; i < 6; i++) begin
            v0 = {v0[8:0], clk_div[0]};
            t0 = {t0[8:0], tick[0]};
            step();
        end
        check("err_ch0_keeps_d3", 32'(v0[5:0]), 32'b110110);
        check("err_ch0_tick", 32'(t0[5:0]), 32'b100100);
        cfg_we_b = 1'b1; cfg_ch_b = 2'd3; cfg_div_b = 8'd5;
        step();
        check("err_ch_range", 32'(cfg_err_b), 32'h1);
        cfg_ch_b = 2'd2;
        step();
        cfg_we_b = 1'b0;
        check("ok_ch_in_range", 32'(cfg_err_b), 32'h0);

        // sync alignment, then sync coincident with ch0 wrap
        wr_cfg(2'd0, 16'd4);
        wr_cfg(2'd1, 16'd6);
        sync = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            v0 = {v0[8:0], clk_div[0]};
            t0 = {t0[8:0], tick[0]};
            v1 = {v1[8:0], clk_div[1]};
            t1 = {t1[8:0], tick[1]};
            sync = (i == 3);
            step();
        end
        sync = 1'b0;
        check("sync_ch0_clk", 32'(v0), 32'b1100110011);
        check("sync_ch0_tick", 32'(t0), 32'b1000100010);
        check("sync_ch1_clk", 32'(v1), 32'b1110111000);
        check("sync_ch1_tick", 32'(t1), 32'b1000100000);

        // enable drop mid-high and re-enable
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("en_pre_hi", 32'(clk_div[0]), 32'h1);
        en = 4'b0010;
        step();
        check("en_off_out", 32'({clk_div[0], tick[0]}), 32'b00);
        check("en_off_ch1", 32'(clk_div[1]), 32'h1);
        en = 4'b0011;
        step();
        check("en_re_start", 32'({clk_div[0], tick[0]}), 32'b11);
        step();
        check("en_re_hi2", 32'({clk_div[0], tick[0]}), 32'b10);
        step();
        check("en_re_lo", 32'(clk_div[0]), 32'h0);

        // async reset mid-period drops outputs and restores defaults
        wr_cfg(2'd1, 16'd2);
        step();
        rst_n = 1'b0;
        #1;
        check("arst_clk_div", 32'(clk_div), 32'h0);
        check("arst_tick", 32'(tick), 32'h0);
        rst_n = 1'b1;
        step();
        hi = 0; hi1 = 0; tk = 0;
        for (int i = 0; i < 10; i++) begin
            hi  += int'(clk_div[0]);
            hi1 += int'(clk_div[1]);
            tk  += int'(tick[0]);
            step();
        end
        check("arst_ch0_default", 32'(hi), 32'd10);
        check("arst_ch1_pend_lost", 32'(hi1), 32'd10);
        check("arst_tick_once", 32'(tk), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
